sc_bimul_rot_acc: RTL and testbench
===================================

Name: sc_bimul_rot_acc

Overview:
- Parametrised bipolar stochastic multiplier for the SC MAC datapath.
- Two internal LFSRs generate the A and B streams. B is rotated: it stalls one cycle each time A completes a period, so the streams decorrelate over long runs.
- Adds a run-length controlled accumulation with a start/busy/done handshake. The output is a binary ones-count, ready to feed the MAC adder tree without an external counter.

Parameters:
- WIDTH, 8, operand/LFSR width. Legal: 4,5,6,7,8,10,12,16.
- CNT_W, 2*WIDTH, width of run length and ones-count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a run. Sampled only in IDLE.
- i_a  in  WIDTH  operand A, unsigned offset-binary bipolar code
- i_b  in  WIDTH  operand B, same coding as i_a
- i_seed_a  in  WIDTH  LFSR A seed
- i_seed_b  in  WIDTH  LFSR B seed
- i_len  in  CNT_W  run length in cycles
- o_busy  out  1  high in RUN and DONE
- o_bit  out  1  product stream bit
- o_bit_vld  out  1  o_bit valid; high only in RUN
- o_done  out  1  one-cycle pulse when the run completes
- o_cnt  out  CNT_W  ones-count of the product stream

Behaviour:
- Reset: state=IDLE; all outputs 0; operand/seed/len registers 0; both LFSRs = 1.
- LFSR: Fibonacci, maximal length (XAPP052 taps). W=8 uses x^8+x^6+x^5+x^4+1. Period 2^WIDTH-1; state is never 0.
- Seed of 0 is replaced by 1 at load.
- FSM states: IDLE, RUN, DONE.
- IDLE + start=1:
  - latch i_a, i_b, i_len;
  - load LFSRs with seeds, after zero-substitution;
  - clear o_cnt and the cycle counter;
  - next state RUN, or DONE if i_len==0.
- IDLE + start=0: stay in IDLE; o_cnt holds its last result.
- RUN, every cycle:
  - a_bit = (a_reg > lfsr_a), unsigned; b_bit = (b_reg > lfsr_b).
  - o_bit = XNOR(a_bit, b_bit), which is bipolar multiplication; o_bit_vld=1.
  - o_cnt += o_bit.
  - lfsr_a always steps.
  - lfsr_b steps except when lfsr_a's next state equals the loaded seed_a (A period wrap). That cycle B holds.
  - When cycle counter == len-1, next state is DONE; otherwise increment the counter.
- DONE, exactly 1 cycle: o_done=1; o_cnt final; o_bit_vld=0; next state IDLE.
- Latency: start sampled at edge T. RUN occupies T+1..T+len. o_done is high in cycle T+len+1. o_busy drops at T+len+2.
- start in RUN or DONE is ignored; there is no queueing.
- No overflow: o_cnt <= len <= 2^CNT_W-1.
- Changes to i_a, i_b, seeds or i_len during a run have no effect.
- rst_n asserted mid-run: immediate return to reset values; the partial count is discarded.

Optional Feature:
- Macro SC_BIMUL_SIGNED_OUT_EN.
- Defined: adds output o_val, signed, CNT_W+1 bits, = 2*o_cnt - len. It is the registered bipolar product scaled by len, valid with o_done and held in IDLE.
- Undefined: port absent; only the ones-count o_cnt exists.

Test Plan:
- WIDTH=8, a=0, b=0, len=100, seeds 0x5A/0xC3 -> o_bit=1 every RUN cycle; o_cnt=100; o_done exactly 101 cycles after start edge; with macro, o_val=+100.
- a=255, b=0, len=255, seed_a=0x01 -> a_bit=0 only when lfsr_a=255, so o_cnt=1; with macro, o_val=-253.
- len=0 -> no o_bit_vld; o_done the next cycle after start; o_cnt=0.
- Rotation: len=510, seed_a=0x01, seed_b=0x80 -> lfsr_b stalls exactly twice, so B advances 508 steps. Bench model matches o_cnt bit-exactly for a=128, b=64.
- seed_a=0, seed_b=0 -> both LFSRs load 1; the sequence equals a run with seeds 1/1.
- start pulsed mid-run is ignored. rst_n low at cycle 50 of a 200-cycle run -> o_busy/o_cnt/o_done=0 immediately; a new start after release runs cleanly.

Source files
------------

// File: rtl/sc_bimul_rot_acc.sv
// Bipolar stochastic multiplier with rotated LFSR B stream and run-length ones-count accumulation.
// Optional macro SC_BIMUL_SIGNED_OUT_EN adds the signed scaled product output o_val.
module sc_bimul_rot_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_seed_a,
  input  logic [WIDTH-1:0] i_seed_b,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_bit,
  output logic             o_bit_vld,
  output logic             o_done,
`ifdef SC_BIMUL_SIGNED_OUT_EN
  output logic signed [CNT_W:0] o_val,
`endif
  output logic [CNT_W-1:0] o_cnt
);

  // Maximal-length tap masks, bit (tap-1) set for each polynomial term.
  localparam logic [15:0] TAPS16 =
    (WIDTH == 4)  ? 16'h000C :
    (WIDTH == 5)  ? 16'h0014 :
    (WIDTH == 6)  ? 16'h0030 :
    (WIDTH == 7)  ? 16'h0060 :
    (WIDTH == 10) ? 16'h0240 :
    (WIDTH == 12) ? 16'h0829 :
    (WIDTH == 16) ? 16'hD008 : 16'h00B8;
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS16[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAP_MASK);
    return {s[WIDTH-2:0], fb};
  endfunction

  function automatic logic [WIDTH-1:0] nonzero_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? WIDTH'(1) : s;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, seed_a_q, seed_a_d;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d, lfsr_a_nxt;
  logic [CNT_W-1:0] len_q, len_d, cyc_q, cyc_d, cnt_q, cnt_d;
  logic             busy_q, busy_d, vld_q, vld_d, done_q, done_d;
  logic             a_bit, b_bit, prod;

  assign a_bit      = (a_q > lfsr_a_q);
  assign b_bit      = (b_q > lfsr_b_q);
  assign prod       = vld_q & ~(a_bit ^ b_bit);
  assign lfsr_a_nxt = lfsr_step(lfsr_a_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    seed_a_d = seed_a_q;
    len_d    = len_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = i_a;
          b_d      = i_b;
          len_d    = i_len;
          seed_a_d = nonzero_seed(i_seed_a);
          lfsr_a_d = nonzero_seed(i_seed_a);
          lfsr_b_d = nonzero_seed(i_seed_b);
          cnt_d    = '0;
          cyc_d    = '0;
          state_d  = (i_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_d    = cnt_q + CNT_W'(prod);
        lfsr_a_d = lfsr_a_nxt;
        // B holds for one cycle whenever A wraps back to its seed.
        if (lfsr_a_nxt != seed_a_q) lfsr_b_d = lfsr_step(lfsr_b_q);
        if (cyc_q == len_q - CNT_W'(1)) state_d = DONE;
        else cyc_d = cyc_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    vld_d  = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      seed_a_q <= '0;
      len_q    <= '0;
      lfsr_a_q <= WIDTH'(1);
      lfsr_b_q <= WIDTH'(1);
      cyc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      seed_a_q <= seed_a_d;
      len_q    <= len_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_bit     = prod;
  assign o_bit_vld = vld_q;
  assign o_done    = done_q;
  assign o_cnt     = cnt_q;

`ifdef SC_BIMUL_SIGNED_OUT_EN
  // 2*cnt - len always fits in CNT_W+1 signed bits, so modular subtraction is exact.
  function automatic logic signed [CNT_W:0] to_bipolar(input logic [CNT_W-1:0] c,
                                                        input logic [CNT_W-1:0] l);
    logic [CNT_W:0] t;
    t = {c, 1'b0} - {1'b0, l};
    return $signed(t);
  endfunction

  logic signed [CNT_W:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (state_d == DONE) val_d = to_bipolar(cnt_d, len_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign o_val = val_q;
`endif

endmodule

// File: tb/tb_sc_bimul_rot_acc.sv
// Randomized self-checking bench for sc_bimul_rot_acc (WIDTH=8) against a sequence-level reference model.
module tb_sc_bimul_rot_acc;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  i_a, i_b, i_seed_a, i_seed_b;
  logic [15:0] i_len;
  logic        o_busy, o_bit, o_bit_vld, o_done;
  logic [15:0] o_cnt;
`ifdef SC_BIMUL_SIGNED_OUT_EN
  logic signed [16:0] o_val;
`endif

  int total = 0;
  int bad   = 0;
  bit exp_bits [0:1023];

  always #5 clk = ~clk;

  sc_bimul_rot_acc #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_a(i_a), .i_b(i_b),
    .i_seed_a(i_seed_a), .i_seed_b(i_seed_b), .i_len(i_len),
    .o_busy(o_busy), .o_bit(o_bit), .o_bit_vld(o_bit_vld), .o_done(o_done),
`ifdef SC_BIMUL_SIGNED_OUT_EN
    .o_val(o_val),
`endif
    .o_cnt(o_cnt)
  );

  // x^8+x^6+x^5+x^4+1 as a shift register.
  function automatic logic [7:0] nxt8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Reference: build the expected product stream and its ones-count.
  task automatic model_run(input logic [7:0] a, b, sa, sb, input int len, output int cnt);
    logic [7:0] la, lb, seed, nla;
    la = (sa == 0) ? 8'd1 : sa;
    lb = (sb == 0) ? 8'd1 : sb;
    seed = la;
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      bit pb;
      pb = ((a > la) == (b > lb));
      if (i < 1024) exp_bits[i] = pb;
      cnt += int'(pb);
      nla = nxt8(la);
      if (nla != seed) lb = nxt8(lb);
      la = nla;
    end
  endtask

  task automatic do_run(input logic [7:0] a, b, sa, sb, input logic [15:0] len, input int pulse_at,
                        output int lat, output int nvld, output int nmis, output logic [15:0] cnt,
                        output logic signed [16:0] val, output logic tmo,
                        output logic busy_done, output logic busy_after, output logic done_after);
    @(negedge clk);
    i_a = a; i_b = b; i_seed_a = sa; i_seed_b = sb; i_len = len; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    i_a = 8'($urandom); i_b = 8'($urandom); i_seed_a = 8'($urandom); i_seed_b = 8'($urandom);
    i_len = 16'($urandom_range(1, 50));
    lat = 0; nvld = 0; nmis = 0; cnt = '0; val = '0; tmo = 1'b1; busy_done = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == pulse_at) start = 1'b1;
      if (o_bit_vld) begin
        if (nvld < 1024 && o_bit !== exp_bits[nvld]) nmis++;
        nvld++;
      end
      if (o_done) begin
        lat = k; cnt = o_cnt; busy_done = o_busy; tmo = 1'b0;
`ifdef SC_BIMUL_SIGNED_OUT_EN
        val = o_val;
`endif
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    busy_after = o_busy;
    done_after = o_done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; i_a = '0; i_b = '0; i_seed_a = '0; i_seed_b = '0; i_len = '0;
    repeat (3) @(negedge clk);
    total++; if (o_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%0b want=0", o_busy); end
    total++; if (o_bit !== 1'b0)     begin bad++; $display("FAIL reset_bit got=%0b want=0", o_bit); end
    total++; if (o_bit_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", o_bit_vld); end
    total++; if (o_done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%0b want=0", o_done); end
    total++; if (o_cnt !== 16'd0)    begin bad++; $display("FAIL reset_cnt got=%0d want=0", o_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_operands;
    int ecnt, lat, nvld, nmis; logic [15:0] cnt; logic signed [16:0] val; logic tmo, bd, ba, da;
    model_run(8'd0, 8'd0, 8'h5A, 8'hC3, 100, ecnt);
    do_run(8'd0, 8'd0, 8'h5A, 8'hC3, 16'd100, 0, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
    total++; if (tmo !== 1'b0)  begin bad++; $display("FAIL zero_timeout got=%0b want=0", tmo); end
    total++; if (lat != 101)    begin bad++; $display("FAIL zero_latency got=%0d want=101", lat); end
    total++; if (cnt !== 16'd100) begin bad++; $display("FAIL zero_cnt got=%0d want=100", cnt); end
    total++; if (ecnt != 100)   begin bad++; $display("FAIL zero_model got=%0d want=100", ecnt); end
    total++; if (nvld != 100)   begin bad++; $display("FAIL zero_vld_cycles got=%0d want=100", nvld); end
    total++; if (nmis != 0)     begin bad++; $display("FAIL zero_stream got=%0d mismatches want=0", nmis); end
    total++; if (bd !== 1'b1)   begin bad++; $display("FAIL zero_busy_in_done got=%0b want=1", bd); end
    total++; if (ba !== 1'b0)   begin bad++; $display("FAIL zero_busy_after got=%0b want=0", ba); end
    total++; if (da !== 1'b0)   begin bad++; $display("FAIL zero_done_pulse got=%0b want=0", da); end
    total++; if (o_cnt !== 16'd100) begin bad++; $display("FAIL zero_cnt_hold got=%0d want=100", o_cnt); end
`ifdef SC_BIMUL_SIGNED_OUT_EN
    total++; if (val !== 17'sd100) begin bad++; $display("FAIL zero_val got=%0d want=100", val); end
`endif
  endtask

  task automatic test_full_period;
    int ecnt, lat, nvld, nmis; logic [15:0] cnt; logic signed [16:0] val; logic tmo, bd, ba, da;
    logic [7:0] sb;
    sb = 8'($urandom);
    model_run(8'd255, 8'd0, 8'h01, sb, 255, ecnt);
    do_run(8'd255, 8'd0, 8'h01, sb, 16'd255, 0, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL full_cnt got=%0d want=1", cnt); end
    total++; if (lat != 256)    begin bad++; $display("FAIL full_latency got=%0d want=256", lat); end
    total++; if (nmis != 0)     begin bad++; $display("FAIL full_stream got=%0d mismatches want=0", nmis); end
`ifdef SC_BIMUL_SIGNED_OUT_EN
    total++; if (val !== -17'sd253) begin bad++; $display("FAIL full_val got=%0d want=-253", val); end
`endif
  endtask

  task automatic test_len_zero;
    int lat, nvld, nmis; logic [15:0] cnt; logic signed [16:0] val; logic tmo, bd, ba, da;
    do_run(8'd77, 8'd200, 8'h11, 8'h22, 16'd0, 0, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
    total++; if (lat != 1)      begin bad++; $display("FAIL len0_latency got=%0d want=1", lat); end
    total++; if (nvld != 0)     begin bad++; $display("FAIL len0_vld_cycles got=%0d want=0", nvld); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL len0_cnt got=%0d want=0", cnt); end
    total++; if (ba !== 1'b0)   begin bad++; $display("FAIL len0_busy_after got=%0b want=0", ba); end
`ifdef SC_BIMUL_SIGNED_OUT_EN
    total++; if (val !== 17'sd0) begin bad++; $display("FAIL len0_val got=%0d want=0", val); end
`endif
  endtask

  task automatic test_rotation;
    int ecnt, lat, nvld, nmis; logic [15:0] cnt; logic signed [16:0] val; logic tmo, bd, ba, da;
    model_run(8'd128, 8'd64, 8'h01, 8'h80, 510, ecnt);
    do_run(8'd128, 8'd64, 8'h01, 8'h80, 16'd510, 0, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
    total++; if (cnt !== 16'(ecnt)) begin bad++; $display("FAIL rot_cnt got=%0d want=%0d", cnt, ecnt); end
    total++; if (nmis != 0)   begin bad++; $display("FAIL rot_stream got=%0d mismatches want=0", nmis); end
    total++; if (lat != 511)  begin bad++; $display("FAIL rot_latency got=%0d want=511", lat); end
  endtask

  task automatic test_zero_seed;
    int ecnt, lat, nvld, nmis0, nmis1; logic [15:0] cnt0, cnt1; logic signed [16:0] val;
    logic tmo, bd, ba, da; logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    model_run(a, b, 8'd0, 8'd0, 300, ecnt);
    do_run(a, b, 8'd0, 8'd0, 16'd300, 0, lat, nvld, nmis0, cnt0, val, tmo, bd, ba, da);
    do_run(a, b, 8'd1, 8'd1, 16'd300, 0, lat, nvld, nmis1, cnt1, val, tmo, bd, ba, da);
    total++; if (cnt0 !== 16'(ecnt)) begin bad++; $display("FAIL seed0_cnt got=%0d want=%0d", cnt0, ecnt); end
    total++; if (nmis0 != 0) begin bad++; $display("FAIL seed0_stream got=%0d mismatches want=0", nmis0); end
    total++; if (cnt1 !== 16'(ecnt)) begin bad++; $display("FAIL seed1_cnt got=%0d want=%0d", cnt1, ecnt); end
    total++; if (nmis1 != 0) begin bad++; $display("FAIL seed1_stream got=%0d mismatches want=0", nmis1); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int ecnt, lat, nvld, nmis, len; logic [15:0] cnt; logic signed [16:0] val;
      logic tmo, bd, ba, da; logic [7:0] a, b, sa, sb;
      a = 8'($urandom); b = 8'($urandom); sa = 8'($urandom); sb = 8'($urandom);
      len = $urandom_range(1, 400);
      model_run(a, b, sa, sb, len, ecnt);
      do_run(a, b, sa, sb, 16'(len), 0, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
      total++; if (cnt !== 16'(ecnt)) begin bad++; $display("FAIL rand%0d_cnt got=%0d want=%0d", r, cnt, ecnt); end
      total++; if (lat != len + 1) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", r, lat, len + 1); end
      total++; if (nmis != 0) begin bad++; $display("FAIL rand%0d_stream got=%0d mismatches want=0", r, nmis); end
`ifdef SC_BIMUL_SIGNED_OUT_EN
      total++; if (val !== 17'(2 * ecnt - len)) begin bad++; $display("FAIL rand%0d_val got=%0d want=%0d", r, val, 2 * ecnt - len); end
`endif
    end
  endtask

  task automatic test_ignore_start;
    int ecnt, lat, nvld, nmis; logic [15:0] cnt; logic signed [16:0] val; logic tmo, bd, ba, da;
    model_run(8'd150, 8'd90, 8'h3C, 8'h99, 60, ecnt);
    do_run(8'd150, 8'd90, 8'h3C, 8'h99, 16'd60, 20, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
    total++; if (lat != 61) begin bad++; $display("FAIL ignore_latency got=%0d want=61", lat); end
    total++; if (cnt !== 16'(ecnt)) begin bad++; $display("FAIL ignore_cnt got=%0d want=%0d", cnt, ecnt); end
    total++; if (nmis != 0) begin bad++; $display("FAIL ignore_stream got=%0d mismatches want=0", nmis); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL ignore_busy_after got=%0b want=0", ba); end
  endtask

  task automatic test_reset_midrun;
    int ecnt, lat, nvld, nmis; logic [15:0] cnt, pre; logic signed [16:0] val; logic tmo, bd, ba, da;
    @(negedge clk);
    i_a = 8'd0; i_b = 8'd0; i_seed_a = 8'h12; i_seed_b = 8'h34; i_len = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    pre = o_cnt;
    total++; if (pre !== 16'd49) begin bad++; $display("FAIL midrun_partial got=%0d want=49", pre); end
    rst_n = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0)    begin bad++; $display("FAIL midrun_busy got=%0b want=0", o_busy); end
    total++; if (o_cnt !== 16'd0)    begin bad++; $display("FAIL midrun_cnt got=%0d want=0", o_cnt); end
    total++; if (o_done !== 1'b0)    begin bad++; $display("FAIL midrun_done got=%0b want=0", o_done); end
    total++; if (o_bit_vld !== 1'b0) begin bad++; $display("FAIL midrun_vld got=%0b want=0", o_bit_vld); end
    @(negedge clk);
    rst_n = 1'b1;
    model_run(8'd200, 8'd30, 8'h07, 8'hE1, 120, ecnt);
    do_run(8'd200, 8'd30, 8'h07, 8'hE1, 16'd120, 0, lat, nvld, nmis, cnt, val, tmo, bd, ba, da);
    total++; if (cnt !== 16'(ecnt)) begin bad++; $display("FAIL after_reset_cnt got=%0d want=%0d", cnt, ecnt); end
    total++; if (lat != 121) begin bad++; $display("FAIL after_reset_latency got=%0d want=121", lat); end
    total++; if (nmis != 0)  begin bad++; $display("FAIL after_reset_stream got=%0d mismatches want=0", nmis); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_operands();
    test_full_period();
    test_len_zero();
    test_rotation();
    test_zero_seed();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
